// File: rtl/return_address_stack_ckpt.sv
// return_address_stack_ckpt: checkpointable circular return-address stack with RISC-V link hints
module return_address_stack_ckpt #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic             jal_in,
  input  logic             jalr_in,
  input  logic [4:0]       rd_in,
  input  logic [4:0]       rs1_in,
  input  logic [XLEN-1:0]  link_addr_in,
  input  logic             irq_push_in,
  input  logic [XLEN-1:0]  irq_addr_in,
  input  logic             restore_in,
  input  logic [PTR_W-1:0] restore_ptr_in,
  input  logic [PTR_W:0]   restore_count_in,
  input  logic [XLEN-1:0]  restore_top_in,
  output logic [PTR_W-1:0] ckpt_ptr_out,
  output logic [PTR_W:0]   ckpt_count_out,
  output logic [XLEN-1:0]  ckpt_top_out,
  output logic             predict_valid_out,
  output logic [XLEN-1:0]  predict_addr_out,
  output logic             empty_out,
  output logic             full_out
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  logic [XLEN-1:0] mem [DEPTH];
  logic [PTR_W-1:0] tp, tp_inc, tp_dec, waddr;
  logic [PTR_W:0] count, rcount;
  logic [XLEN-1:0] wdata;
  logic link_rd, link_rs1, act, do_push, do_pop, do_pp, we;
  always_comb begin
    link_rd  = rd_in == 5'd1 || rd_in == 5'd5;
    link_rs1 = rs1_in == 5'd1 || rs1_in == 5'd5;
    act      = valid_in && !irq_push_in && !restore_in;
    do_push  = !restore_in && (irq_push_in || act && link_rd &&
               (jal_in || jalr_in && (!link_rs1 || rd_in == rs1_in)));
    do_pop   = act && jalr_in && !link_rd && link_rs1;
    do_pp    = act && jalr_in && link_rd && link_rs1 && rd_in != rs1_in;
    tp_inc   = tp + PTR_W'(1);
    tp_dec   = tp - PTR_W'(1);
    rcount   = restore_count_in > FULL_CNT ? FULL_CNT : restore_count_in;
    we       = restore_in || do_push || do_pp;
    waddr    = restore_in ? restore_ptr_in : do_push ? tp_inc : tp;
    wdata    = restore_in ? restore_top_in : irq_push_in ? irq_addr_in : link_addr_in;
  end
  // storage is deliberately left unreset; count alone decides what is live
  always_ff @(posedge clk_in)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      tp                <= PTR_W'(DEPTH-1);
      count             <= '0;
      predict_valid_out <= 1'b0;
      predict_addr_out  <= '0;
    end else begin
      predict_valid_out <= 1'b0;
      if (restore_in) begin
        tp    <= restore_ptr_in;
        count <= rcount;
      end else if (do_push) begin
        tp    <= tp_inc;
        count <= full_out ? count : count + 1'b1;
      end else if (do_pop) begin
        if (!empty_out) begin
          predict_addr_out  <= mem[tp];
          predict_valid_out <= 1'b1;
          tp                <= tp_dec;
          count             <= count - 1'b1;
        end
      end else if (do_pp) begin
        predict_addr_out  <= mem[tp];
        predict_valid_out <= !empty_out;
        if (empty_out) count <= (PTR_W+1)'(1);
      end
    end
  assign ckpt_ptr_out   = tp;
  assign ckpt_count_out = count;
  assign ckpt_top_out   = mem[tp];
  assign empty_out      = count == '0;
  assign full_out       = count == FULL_CNT;
endmodule

// File: doc/return_address_stack_ckpt.md
Name: return_address_stack_ckpt

Overview:
- Parametrised, checkpointable return-address stack (RAS) for the RISC-V fetch/branch-prediction path. It succeeds the fixed 16x64 stack.
- Applies the RISC-V link-register hint rules (x1/x5) to JAL/JALR, plus interrupt-entry pushes.
- Stores entries in a circular buffer that overwrites the oldest entry on overflow.
- Exports pointer/count checkpoints, so the pipeline can restore the stack (including a top-entry repair) on a mispredict or flush.

Parameters:
- XLEN, 64, address width.
- DEPTH, 16, number of entries. Must be a power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width. Derived; do not override.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- valid_in  in  1  a resolved jump instruction is presented this cycle.
- jal_in  in  1  instruction is JAL.
- jalr_in  in  1  instruction is JALR. At most one of jal_in/jalr_in is set when valid_in=1.
- rd_in  in  5  destination register.
- rs1_in  in  5  source register (JALR only).
- link_addr_in  in  XLEN  return address to push (PC+4).
- irq_push_in  in  1  interrupt entry; push irq_addr_in.
- irq_addr_in  in  XLEN  interrupted PC.
- restore_in  in  1  restore from checkpoint.
- restore_ptr_in  in  PTR_W  checkpointed top pointer.
- restore_count_in  in  PTR_W+1  checkpointed count.
- restore_top_in  in  XLEN  checkpointed top entry value.
- ckpt_ptr_out  out  PTR_W  current top pointer.
- ckpt_count_out  out  PTR_W+1  current count.
- ckpt_top_out  out  XLEN  entry at current top.
- predict_valid_out  out  1  registered pop result is valid.
- predict_addr_out  out  XLEN  predicted return address.
- empty_out  out  1  count==0.
- full_out  out  1  count==DEPTH.

Behaviour:
- State:
  - mem[DEPTH] of XLEN bits, not reset.
  - tp, the index of the top entry.
  - count, saturating at 0..DEPTH.
- Reset (async):
  - tp=DEPTH-1, count=0.
  - predict_valid_out=0, predict_addr_out=0.
  - Therefore empty_out=1 and full_out=0.
- link(r) = (r==1 || r==5).
- Action decode when valid_in=1:
  - JAL: push if link(rd), else none.
  - JALR, !link(rd) & !link(rs1): none.
  - JALR, !link(rd) & link(rs1): pop.
  - JALR, link(rd) & !link(rs1): push.
  - JALR, link(rd) & link(rs1) & rd!=rs1: pop-then-push.
  - JALR, link(rd) & link(rs1) & rd==rs1: push.
- Push:
  - tp<=tp+1 (mod DEPTH) and mem[tp+1]<=addr.
  - count<=min(count+1, DEPTH).
  - At full, the oldest entry is silently overwritten.
- Pop:
  - If count>0: predict_addr_out<=mem[tp], predict_valid_out<=1, tp<=tp-1 (mod DEPTH), count<=count-1.
  - If count==0: predict_valid_out<=0, tp and count unchanged, predict_addr_out holds.
- Pop-then-push:
  - predict_addr_out<=mem[tp] with predict_valid_out<=(count>0).
  - mem[tp]<=link_addr_in and tp is unchanged.
  - count<=max(count,1).
- predict_valid_out is a one-cycle pulse, with latency of 1 clock after the pop cycle. It is 0 on all other cycles.
- Priority per cycle: restore_in > irq_push_in > valid_in. Lower-priority requests in the same cycle are dropped (no stall, no queueing).
- Restore:
  - tp<=restore_ptr_in, count<=restore_count_in, mem[restore_ptr_in]<=restore_top_in.
  - predict_valid_out<=0.
  - restore_count_in>DEPTH is clamped to DEPTH.
- irq_push_in performs a push of irq_addr_in regardless of rd/rs1.
- Checkpoint outputs are combinational from current registers (ckpt_top_out=mem[tp]). The pipeline samples them in the cycle before it issues the jump.
- Known limitation, accepted: entries below top that are overwritten by wrong-path pushes are not repaired.

Test Plan:
- DEPTH=4. Reset, then JAL rd=1 with link 0x100, 0x104, 0x108 on consecutive cycles. Then JALR rd=0 rs1=1 three times. Required: predict_addr_out=0x108, 0x104, 0x100, each with predict_valid_out=1 one cycle after its pop. empty_out=1 at end.
- Overflow: push 0x10, 0x20, 0x30, 0x40, 0x50 (full_out=1 after the 4th push). Pop 5 times. Required: predictions 0x50, 0x40, 0x30, 0x20, then predict_valid_out=0 on the 5th pop with count staying 0.
- Hint rules:
  - JALR rd=5 rs1=1 with stack top 0x200 and link 0x300. Required: prediction 0x200, count unchanged, new top 0x300.
  - JALR rd=1 rs1=1. Required: push only.
  - JAL rd=2. Required: no change.
- Checkpoint/restore: capture ckpt (ptr=1, count=2, top=0x44). Then wrong-path push 0x99, then restore with the captured values. Required: next pop predicts 0x44, the following pop predicts the original second entry.
- Priority: in one cycle, set restore_in, irq_push_in and a valid JAL rd=1. Required: only the restore takes effect, and count equals restore_count_in.
- Async reset asserted mid-pop between clock edges. Required: predict_valid_out=0 and empty_out=1 immediately, with no clock edge needed. The next pop after deassertion gives predict_valid_out=0.
